// File: rtl/rv32_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv32_ctrl_pkg
// Shared definitions for the RV32I(+M) ID-stage control unit: major opcode
// constants, ALU operation codes (base and M-extension), and the control
// bundle that travels from the decoder into the ID/EX register.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32_ctrl_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct7 that selects the multiply/divide group on OP
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam int ALU_CODE_W = 6;

    // Base ops 0..7 line up with funct3 so OP/OP-IMM can cast funct3 directly;
    // M ops 16..23 are {3'b010, funct3}.
    typedef enum logic [ALU_CODE_W-1:0] {
        ALU_ADD    = 6'd0,
        ALU_SLL    = 6'd1,
        ALU_SLT    = 6'd2,
        ALU_SLTU   = 6'd3,
        ALU_XOR    = 6'd4,
        ALU_SRL    = 6'd5,
        ALU_OR     = 6'd6,
        ALU_AND    = 6'd7,
        ALU_SRA    = 6'd8,
        ALU_SUB    = 6'd9,
        ALU_INV    = 6'd15,
        ALU_MUL    = 6'd16,
        ALU_MULH   = 6'd17,
        ALU_MULHSU = 6'd18,
        ALU_MULHU  = 6'd19,
        ALU_DIV    = 6'd20,
        ALU_DIVU   = 6'd21,
        ALU_REM    = 6'd22,
        ALU_REMU   = 6'd23
    } alu_op_e;

    // Decoded control bundle; also the content of the ID/EX register.
    // rs1/rs2/rd are zero whenever the instruction does not use the field.
    typedef struct packed {
        logic        alusrc;
        logic        dmem_to_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
        alu_op_e     alu_op;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } ctrl_bundle_t;

    localparam int CTRL_BUNDLE_W = $bits(ctrl_bundle_t);

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// ---------------------------------------------------------------------------
// ctrl_decode_pipe_if
// Bundles the fetch->ID handshake, the flush, the ID->EX handshake and the
// registered control outputs of the ID stage.
//
// Handshake rules (both sides):
//   fetch->ID : an instruction transfers on a clock edge where instr_valid_i
//               and instr_ready_o are both 1. instr_ready_o may depend
//               combinationally on instr_valid_i/instr_i (load-use check)
//               and flush_i; instr_valid_i must not depend on instr_ready_o.
//   ID->EX    : the ID/EX register is consumed on an edge where ctrl_valid_o
//               and ex_ready_i are both 1. While ctrl_valid_o=1 and
//               ex_ready_i=0 every control output holds.
//
// Modports:
//   master : the fetch/EX environment around the ID stage
//   slave  : the ID stage (ctrl_decode_pipe)
// ---------------------------------------------------------------------------
interface ctrl_decode_pipe_if #(
    parameter int ALU_OP_W = 6,
    parameter int CNT_W    = 16
);
    logic                instr_valid_i;
    logic [31:0]         instr_i;
    logic                instr_ready_o;
    logic                flush_i;
    logic                ex_ready_i;
    logic                ctrl_valid_o;
    logic                alusrc_o;
    logic                dmem_to_reg_o;
    logic                reg_write_o;
    logic                mem_read_o;
    logic                mem_write_o;
    logic                branch_o;
    logic                jump_o;
    logic [ALU_OP_W-1:0] alu_op_o;
    logic [2:0]          funct3_o;
    logic [4:0]          rs1_o;
    logic [4:0]          rs2_o;
    logic [4:0]          rd_o;
    logic                illegal_o;
    logic [CNT_W-1:0]    bubble_cnt_o;
    logic [CNT_W-1:0]    instr_cnt_o;

    modport master (
        output instr_valid_i, instr_i, flush_i, ex_ready_i,
        input  instr_ready_o, ctrl_valid_o, alusrc_o, dmem_to_reg_o,
               reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o,
               alu_op_o, funct3_o, rs1_o, rs2_o, rd_o, illegal_o,
               bubble_cnt_o, instr_cnt_o
    );

    modport slave (
        input  instr_valid_i, instr_i, flush_i, ex_ready_i,
        output instr_ready_o, ctrl_valid_o, alusrc_o, dmem_to_reg_o,
               reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o,
               alu_op_o, funct3_o, rs1_o, rs2_o, rd_o, illegal_o,
               bubble_cnt_o, instr_cnt_o
    );
endinterface

// File: rtl/rv32_ctrl_decode.sv
// ---------------------------------------------------------------------------
// rv32_ctrl_decode
// Purely combinational RV32I(+M) decoder: instruction word -> control bundle.
// The bundle's rs1/rs2 fields double as the "register actually read"
// indices used by the load-use check (zero when the field is unused).
// Ports:
//   instr   in  32  instruction word
//   bundle  out     decoded control bundle (ctrl_bundle_t)
// Parameter:
//   ENABLE_M  1: decode MUL..REMU on OP; 0: those encodings are illegal
// ---------------------------------------------------------------------------
module rv32_ctrl_decode
    import rv32_ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0]  instr,
    output ctrl_bundle_t bundle
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        bundle        = '0;
        bundle.funct3 = funct3;
        bundle.alu_op = ALU_ADD;
        bad           = 1'b0;

        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                bundle.alusrc    = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.rd        = instr[11:7];
            end
            OPC_JAL: begin
                bundle.jump      = 1'b1;
                bundle.alusrc    = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.rd        = instr[11:7];
            end
            OPC_JALR: begin
                bundle.jump      = 1'b1;
                bundle.alusrc    = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.rs1       = instr[19:15];
                bundle.rd        = instr[11:7];
            end
            OPC_BRANCH: begin
                bundle.branch = 1'b1;
                bundle.rs1    = instr[19:15];
                bundle.rs2    = instr[24:20];
                case (funct3)
                    3'd0, 3'd1: bundle.alu_op = ALU_SUB;
                    3'd4, 3'd5: bundle.alu_op = ALU_SLT;
                    3'd6, 3'd7: bundle.alu_op = ALU_SLTU;
                    default:    bad           = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                bundle.mem_read    = 1'b1;
                bundle.dmem_to_reg = 1'b1;
                bundle.alusrc      = 1'b1;
                bundle.reg_write   = 1'b1;
                bundle.rs1         = instr[19:15];
                bundle.rd          = instr[11:7];
            end
            OPC_STORE: begin
                bundle.mem_write = 1'b1;
                bundle.alusrc    = 1'b1;
                bundle.rs1       = instr[19:15];
                bundle.rs2       = instr[24:20];
            end
            OPC_OPIMM: begin
                bundle.alusrc    = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.rs1       = instr[19:15];
                bundle.rd        = instr[11:7];
                // instr[30] is part of the immediate except for shifts
                if (funct3 == 3'd5 && instr[30])
                    bundle.alu_op = ALU_SRA;
                else
                    bundle.alu_op = alu_op_e'({3'b000, funct3});
            end
            OPC_OP: begin
                bundle.reg_write = 1'b1;
                bundle.rs1       = instr[19:15];
                bundle.rs2       = instr[24:20];
                bundle.rd        = instr[11:7];
                if (funct7 == FUNCT7_MULDIV) begin
                    if (ENABLE_M)
                        bundle.alu_op = alu_op_e'({3'b010, funct3});
                    else
                        bad = 1'b1;
                end else if (funct3 == 3'd0 && instr[30]) begin
                    bundle.alu_op = ALU_SUB;
                end else if (funct3 == 3'd5 && instr[30]) begin
                    bundle.alu_op = ALU_SRA;
                end else begin
                    bundle.alu_op = alu_op_e'({3'b000, funct3});
                end
            end
            default: bad = 1'b1;
        endcase

        // An illegal instruction still travels down the pipe, but with every
        // side effect removed and no register indices that could raise a
        // spurious load-use stall.
        if (bad) begin
            bundle         = '0;
            bundle.funct3  = funct3;
            bundle.illegal = 1'b1;
            bundle.alu_op  = ALU_INV;
        end
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_decode_pipe
// Registered RV32I(+M) ID-stage control unit. Decodes the presented
// instruction, loads the control bundle into the ID/EX register, stalls one
// cycle on a load-use dependency, supports branch flush, and counts accepted
// instructions and inserted bubbles.
// Ports:
//   clk_i    in  clock
//   reset_i  in  asynchronous active-high reset
//   bus      ctrl_decode_pipe_if.slave: fetch handshake (instr_valid_i,
//            instr_i, instr_ready_o), flush_i, EX handshake (ctrl_valid_o,
//            ex_ready_i), registered control outputs and perf counters
// Parameters:
//   ENABLE_M  decode RV32M when 1
//   ALU_OP_W  width of alu_op_o
//   CNT_W     width of the perf counters (wrap modulo 2^CNT_W)
// ---------------------------------------------------------------------------
module ctrl_decode_pipe
    import rv32_ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0,
    parameter int ALU_OP_W = 6,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    ctrl_decode_pipe_if.slave bus
);

    ctrl_bundle_t     dec;
    ctrl_bundle_t     q;
    logic             valid_q;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] instr_cnt;
    logic             adv;
    logic             hazard;
    logic             take;

    rv32_ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
        .instr  (bus.instr_i),
        .bundle (dec)
    );

    // The ID/EX slot can take a new entry when it is empty or being drained.
    assign adv = ~valid_q | bus.ex_ready_i;

    // Load in ID/EX whose destination is read by the incoming instruction.
    // Unused source fields decode to x0 and x0 destinations are excluded,
    // so neither can create a false stall.
    assign hazard = valid_q & q.mem_read & (q.rd != 5'd0) & bus.instr_valid_i &
                    ((dec.rs1 == q.rd) | (dec.rs2 == q.rd));

    assign take = adv & bus.instr_valid_i & ~hazard;

    assign bus.instr_ready_o = ~reset_i & adv & ~hazard & ~bus.flush_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q    <= 1'b0;
            q          <= '0;
            bubble_cnt <= '0;
            instr_cnt  <= '0;
        end else if (bus.flush_i) begin
            // Kill both the registered and the presented instruction.
            valid_q <= 1'b0;
            q       <= '0;
        end else if (take) begin
            valid_q   <= 1'b1;
            q         <= dec;
            instr_cnt <= instr_cnt + 1'b1;
        end else if (adv) begin
            // Bubble: the slot empties. Clearing mem_read is what lets the
            // load-use stall release after exactly one cycle.
            valid_q <= 1'b0;
            q       <= '0;
            if (hazard)
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign bus.ctrl_valid_o  = valid_q;
    assign bus.alusrc_o      = q.alusrc;
    assign bus.dmem_to_reg_o = q.dmem_to_reg;
    assign bus.reg_write_o   = q.reg_write;
    assign bus.mem_read_o    = q.mem_read;
    assign bus.mem_write_o   = q.mem_write;
    assign bus.branch_o      = q.branch;
    assign bus.jump_o        = q.jump;
    assign bus.alu_op_o      = ALU_OP_W'(q.alu_op);
    assign bus.funct3_o      = q.funct3;
    assign bus.rs1_o         = q.rs1;
    assign bus.rs2_o         = q.rs2;
    assign bus.rd_o          = q.rd;
    assign bus.illegal_o     = q.illegal;
    assign bus.bubble_cnt_o  = bubble_cnt;
    assign bus.instr_cnt_o   = instr_cnt;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_ctrl_decode_pipe
// Directed bench for ctrl_decode_pipe. Two instances share one stimulus
// stream: dut_m (ENABLE_M=1, CNT_W=16) and dut_n (ENABLE_M=0, CNT_W=4, so
// its counters wrap within the run).
// ---------------------------------------------------------------------------
module tb_ctrl_decode_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        flush;
    logic        ex_ready;

    ctrl_decode_pipe_if #(.ALU_OP_W(6), .CNT_W(16)) bus_m ();
    ctrl_decode_pipe_if #(.ALU_OP_W(6), .CNT_W(4))  bus_n ();

    assign bus_m.instr_valid_i = instr_valid;
    assign bus_m.instr_i       = instr;
    assign bus_m.flush_i       = flush;
    assign bus_m.ex_ready_i    = ex_ready;
    assign bus_n.instr_valid_i = instr_valid;
    assign bus_n.instr_i       = instr;
    assign bus_n.flush_i       = flush;
    assign bus_n.ex_ready_i    = ex_ready;

    ctrl_decode_pipe #(.ENABLE_M(1'b1), .ALU_OP_W(6), .CNT_W(16)) dut_m (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus_m)
    );

    ctrl_decode_pipe #(.ENABLE_M(1'b0), .ALU_OP_W(6), .CNT_W(4)) dut_n (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus_n)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int exp_instr  = 0;
    int exp_bubble = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w);
        instr_valid = v;
        instr       = w;
    endtask

    // flags = {alusrc, dmem_to_reg, reg_write, mem_read, mem_write, branch, jump}
    function automatic logic [6:0] flags_m();
        return {bus_m.alusrc_o, bus_m.dmem_to_reg_o, bus_m.reg_write_o,
                bus_m.mem_read_o, bus_m.mem_write_o, bus_m.branch_o, bus_m.jump_o};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  alu_op;
        logic [6:0]  flags;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
        logic        nom_illegal;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    initial begin
        // ---------------- vector table ----------------
        vecs[0]  = '{32'h002081B3, 6'd0,  7'b0010000, 5'd1,  5'd2, 5'd3,  1'b0, 1'b0}; // ADD x3,x1,x2
        vecs[1]  = '{32'h40208233, 6'd9,  7'b0010000, 5'd1,  5'd2, 5'd4,  1'b0, 1'b0}; // SUB x4,x1,x2
        vecs[2]  = '{32'h407352B3, 6'd8,  7'b0010000, 5'd6,  5'd7, 5'd5,  1'b0, 1'b0}; // SRA x5,x6,x7
        vecs[3]  = '{32'h00510093, 6'd0,  7'b1010000, 5'd2,  5'd0, 5'd1,  1'b0, 1'b0}; // ADDI x1,x2,5
        vecs[4]  = '{32'h4034D413, 6'd8,  7'b1010000, 5'd9,  5'd0, 5'd8,  1'b0, 1'b0}; // SRAI x8,x9,3
        vecs[5]  = '{32'hFFF5C513, 6'd4,  7'b1010000, 5'd11, 5'd0, 5'd10, 1'b0, 1'b0}; // XORI x10,x11,-1
        vecs[6]  = '{32'h12345637, 6'd0,  7'b1010000, 5'd0,  5'd0, 5'd12, 1'b0, 1'b0}; // LUI x12
        vecs[7]  = '{32'h00001697, 6'd0,  7'b1010000, 5'd0,  5'd0, 5'd13, 1'b0, 1'b0}; // AUIPC x13
        vecs[8]  = '{32'h000000EF, 6'd0,  7'b1010001, 5'd0,  5'd0, 5'd1,  1'b0, 1'b0}; // JAL x1
        vecs[9]  = '{32'h00008067, 6'd0,  7'b1010001, 5'd1,  5'd0, 5'd0,  1'b0, 1'b0}; // JALR x0,0(x1)
        vecs[10] = '{32'h00208063, 6'd9,  7'b0000010, 5'd1,  5'd2, 5'd0,  1'b0, 1'b0}; // BEQ x1,x2
        vecs[11] = '{32'h0041C063, 6'd2,  7'b0000010, 5'd3,  5'd4, 5'd0,  1'b0, 1'b0}; // BLT x3,x4
        vecs[12] = '{32'h0062F063, 6'd3,  7'b0000010, 5'd5,  5'd6, 5'd0,  1'b0, 1'b0}; // BGEU x5,x6
        vecs[13] = '{32'h00442383, 6'd0,  7'b1111000, 5'd8,  5'd0, 5'd7,  1'b0, 1'b0}; // LW x7,4(x8)
        vecs[14] = '{32'h00952423, 6'd0,  7'b1000100, 5'd10, 5'd9, 5'd0,  1'b0, 1'b0}; // SW x9,8(x10)
        vecs[15] = '{32'h023100B3, 6'd16, 7'b0010000, 5'd2,  5'd3, 5'd1,  1'b0, 1'b1}; // MUL x1,x2,x3
        vecs[16] = '{32'h0262D233, 6'd21, 7'b0010000, 5'd5,  5'd6, 5'd4,  1'b0, 1'b1}; // DIVU x4,x5,x6
        vecs[17] = '{32'h00002063, 6'd15, 7'b0000000, 5'd0,  5'd0, 5'd0,  1'b1, 1'b1}; // BRANCH f3=2
        vecs[18] = '{32'h0000007F, 6'd15, 7'b0000000, 5'd0,  5'd0, 5'd0,  1'b1, 1'b1}; // opcode 0x7F
        vecs[19] = '{32'h00000000, 6'd15, 7'b0000000, 5'd0,  5'd0, 5'd0,  1'b1, 1'b1}; // all zero

        // ---------------- reset ----------------
        reset    = 1'b1;
        flush    = 1'b0;
        ex_ready = 1'b1;
        drive(1'b1, 32'h002081B3);
        step();
        step();
        chk("rst ctrl_valid",  32'(bus_m.ctrl_valid_o), 32'd0);
        chk("rst instr_ready", 32'(bus_m.instr_ready_o), 32'd0);
        chk("rst reg_write",   32'(bus_m.reg_write_o), 32'd0);
        chk("rst alu_op",      32'(bus_m.alu_op_o), 32'd0);
        chk("rst instr_cnt",   32'(bus_m.instr_cnt_o), 32'd0);
        chk("rst bubble_cnt",  32'(bus_m.bubble_cnt_o), 32'd0);
        reset = 1'b0;

        // ---------------- table: one instruction per cycle ----------------
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].instr);
            #1;
            chk($sformatf("v%0d instr_ready", i), 32'(bus_m.instr_ready_o), 32'd1);
            step();
            exp_instr++;
            chk($sformatf("v%0d ctrl_valid", i), 32'(bus_m.ctrl_valid_o), 32'd1);
            chk($sformatf("v%0d alu_op", i),     32'(bus_m.alu_op_o), 32'(vecs[i].alu_op));
            chk($sformatf("v%0d flags", i),      32'(flags_m()), 32'(vecs[i].flags));
            chk($sformatf("v%0d rs1", i),        32'(bus_m.rs1_o), 32'(vecs[i].rs1));
            chk($sformatf("v%0d rs2", i),        32'(bus_m.rs2_o), 32'(vecs[i].rs2));
            chk($sformatf("v%0d rd", i),         32'(bus_m.rd_o), 32'(vecs[i].rd));
            chk($sformatf("v%0d funct3", i),     32'(bus_m.funct3_o), 32'(vecs[i].instr[14:12]));
            chk($sformatf("v%0d illegal", i),    32'(bus_m.illegal_o), 32'(vecs[i].illegal));
            chk($sformatf("v%0d nom illegal", i), 32'(bus_n.illegal_o), 32'(vecs[i].nom_illegal));
            if (vecs[i].nom_illegal) begin
                chk($sformatf("v%0d nom reg_write", i), 32'(bus_n.reg_write_o), 32'd0);
                chk($sformatf("v%0d nom alu_op", i),    32'(bus_n.alu_op_o), 32'd15);
            end
        end
        drive(1'b0, 32'h0);
        step();
        chk("idle ctrl_valid", 32'(bus_m.ctrl_valid_o), 32'd0);

        // ---------------- load-use: LW x5 then ADD x6,x5,x2 ----------------
        drive(1'b1, 32'h0000A283);
        step();
        exp_instr++;
        chk("lu load mem_read", 32'(bus_m.mem_read_o), 32'd1);
        drive(1'b1, 32'h00228333);
        #1;
        chk("lu stall ready", 32'(bus_m.instr_ready_o), 32'd0);
        step();
        exp_bubble++;
        chk("lu bubble valid", 32'(bus_m.ctrl_valid_o), 32'd0);
        chk("lu bubble_cnt",   32'(bus_m.bubble_cnt_o), 32'(exp_bubble));
        #1;
        chk("lu resume ready", 32'(bus_m.instr_ready_o), 32'd1);
        step();
        exp_instr++;
        chk("lu add valid", 32'(bus_m.ctrl_valid_o), 32'd1);
        chk("lu add rd",    32'(bus_m.rd_o), 32'd6);
        chk("lu add rs1",   32'(bus_m.rs1_o), 32'd5);

        // ---------------- LW x0 then ADD x6,x0,x2: no stall ----------------
        drive(1'b1, 32'h0000A003);
        step();
        exp_instr++;
        drive(1'b1, 32'h00200333);
        #1;
        chk("x0 ready", 32'(bus_m.instr_ready_o), 32'd1);
        step();
        exp_instr++;
        chk("x0 add valid",   32'(bus_m.ctrl_valid_o), 32'd1);
        chk("x0 add rd",      32'(bus_m.rd_o), 32'd6);
        chk("x0 bubble_cnt",  32'(bus_m.bubble_cnt_o), 32'(exp_bubble));

        // ---------------- EX backpressure with SUB held ----------------
        drive(1'b1, 32'h40208233);
        step();
        exp_instr++;
        drive(1'b1, 32'h00510093);
        ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d ready", k), 32'(bus_m.instr_ready_o), 32'd0);
            step();
            chk($sformatf("stall%0d valid", k),  32'(bus_m.ctrl_valid_o), 32'd1);
            chk($sformatf("stall%0d alu_op", k), 32'(bus_m.alu_op_o), 32'd9);
            chk($sformatf("stall%0d rd", k),     32'(bus_m.rd_o), 32'd4);
            chk($sformatf("stall%0d cnt", k),    32'(bus_m.instr_cnt_o), 32'(exp_instr));
        end
        ex_ready = 1'b1;
        #1;
        chk("stall release ready", 32'(bus_m.instr_ready_o), 32'd1);
        step();
        exp_instr++;
        chk("stall next alu_op", 32'(bus_m.alu_op_o), 32'd0);
        chk("stall next rd",     32'(bus_m.rd_o), 32'd1);
        chk("stall next alusrc", 32'(bus_m.alusrc_o), 32'd1);

        // ---------------- flush with BEQ registered, ADDI presented ----------------
        drive(1'b1, 32'h00208063);
        step();
        exp_instr++;
        chk("fl beq branch", 32'(bus_m.branch_o), 32'd1);
        drive(1'b1, 32'h00510093);
        flush = 1'b1;
        #1;
        chk("fl ready", 32'(bus_m.instr_ready_o), 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        chk("fl valid",     32'(bus_m.ctrl_valid_o), 32'd0);
        chk("fl branch",    32'(bus_m.branch_o), 32'd0);
        chk("fl instr_cnt", 32'(bus_m.instr_cnt_o), 32'(exp_instr));

        // ---------------- counters (dut_n wraps at 16) ----------------
        chk("m instr_cnt",  32'(bus_m.instr_cnt_o), 32'(exp_instr % 65536));
        chk("n instr_cnt",  32'(bus_n.instr_cnt_o), 32'(exp_instr % 16));
        chk("m bubble_cnt", 32'(bus_m.bubble_cnt_o), 32'(exp_bubble));
        chk("n bubble_cnt", 32'(bus_n.bubble_cnt_o), 32'(exp_bubble));

        // ---------------- async reset mid-stream ----------------
        drive(1'b1, 32'h002081B3);
        step();
        chk("ar add valid", 32'(bus_m.ctrl_valid_o), 32'd1);
        drive(1'b1, 32'h40208233);
        #2;
        reset = 1'b1;
        #1;
        chk("ar valid",     32'(bus_m.ctrl_valid_o), 32'd0);
        chk("ar ready",     32'(bus_m.instr_ready_o), 32'd0);
        chk("ar instr_cnt", 32'(bus_m.instr_cnt_o), 32'd0);
        chk("ar rd",        32'(bus_m.rd_o), 32'd0);
        step();
        chk("ar held valid", 32'(bus_m.ctrl_valid_o), 32'd0);
        reset = 1'b0;
        #1;
        chk("ar release ready", 32'(bus_m.instr_ready_o), 32'd1);
        step();
        chk("ar sub valid",  32'(bus_m.ctrl_valid_o), 32'd1);
        chk("ar sub alu_op", 32'(bus_m.alu_op_o), 32'd9);
        chk("ar instr_cnt1", 32'(bus_m.instr_cnt_o), 32'd1);
        drive(1'b0, 32'h0);
        step();

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
